// File: rtl/orgasmall_core.sv
// OrgaSmall single-cycle 8-bit core: decoder, ALU with C/Z/N flags,
// 8-entry register file, instruction memory and data memory.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_we/waddr/wdata      program-load write port into instruction memory
//   dbg_reg_idx/dbg_reg_data combinational view of R[dbg_reg_idx]
//   dbg_mem_addr/data        combinational view of DMEM[dbg_mem_addr]
//   pc, flags {C,Z,N}        committed program counter and flags
//   halted                   set by an invalid opcode, cleared by reset
module orgasmall_core #(
    parameter int WORD_SIZE     = 8,
    parameter int ADDR_SIZE     = 8,
    parameter int NUM_REGISTERS = 8,
    parameter int INST_SIZE     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 imem_we,
    input  logic [ADDR_SIZE-1:0] imem_waddr,
    input  logic [INST_SIZE-1:0] imem_wdata,
    input  logic [2:0]           dbg_reg_idx,
    output logic [WORD_SIZE-1:0] dbg_reg_data,
    input  logic [ADDR_SIZE-1:0] dbg_mem_addr,
    output logic [WORD_SIZE-1:0] dbg_mem_data,
    output logic [ADDR_SIZE-1:0] pc,
    output logic [2:0]           flags,
    output logic                 halted
);

    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_ADC   = 5'b00010;
    localparam logic [4:0] OP_SUB   = 5'b00011;
    localparam logic [4:0] OP_AND   = 5'b00100;
    localparam logic [4:0] OP_OR    = 5'b00101;
    localparam logic [4:0] OP_XOR   = 5'b00110;
    localparam logic [4:0] OP_CMP   = 5'b00111;
    localparam logic [4:0] OP_MOV   = 5'b01000;
    localparam logic [4:0] OP_STR   = 5'b10000;
    localparam logic [4:0] OP_LOAD  = 5'b10001;
    localparam logic [4:0] OP_RSTR  = 5'b10010;
    localparam logic [4:0] OP_RLOAD = 5'b10011;
    localparam logic [4:0] OP_JMP   = 5'b10100;
    localparam logic [4:0] OP_JC    = 5'b10101;
    localparam logic [4:0] OP_JZ    = 5'b10110;
    localparam logic [4:0] OP_JN    = 5'b10111;
    localparam logic [4:0] OP_INC   = 5'b11000;
    localparam logic [4:0] OP_DEC   = 5'b11001;
    localparam logic [4:0] OP_SHR   = 5'b11010;
    localparam logic [4:0] OP_SHL   = 5'b11011;
    localparam logic [4:0] OP_SET   = 5'b11111;

    logic [INST_SIZE-1:0] imem [0:(1<<ADDR_SIZE)-1];
    logic [WORD_SIZE-1:0] dmem [0:(1<<ADDR_SIZE)-1];
    logic [WORD_SIZE-1:0] regs [0:NUM_REGISTERS-1];
    logic                 c_f, z_f, n_f;

    logic [INST_SIZE-1:0] inst;
    logic [4:0]           op;
    logic [2:0]           rx, ry;
    logic [7:0]           m;
    logic [WORD_SIZE-1:0] rx_val, ry_val;

    // wide[WORD_SIZE] carries the carry/borrow/shifted-out bit
    logic [WORD_SIZE:0]   wide;
    logic                 flag_we, alu_wb, reg_we, mem_we, valid;
    logic [WORD_SIZE-1:0] reg_wdata, mem_wdata;
    logic [ADDR_SIZE-1:0] mem_addr, pc_next;

    assign inst   = imem[pc];
    assign op     = inst[15:11];
    assign rx     = inst[10:8];
    assign ry     = inst[7:5];
    assign m      = inst[7:0];
    assign rx_val = regs[rx];
    assign ry_val = regs[ry];

    always_comb begin
        wide      = '0;
        flag_we   = 1'b0;
        alu_wb    = 1'b0;
        reg_we    = 1'b0;
        reg_wdata = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        valid     = 1'b1;
        pc_next   = pc + ADDR_SIZE'(1);
        case (op)
            OP_ADD: begin
                wide = {1'b0, rx_val} + {1'b0, ry_val};
                flag_we = 1'b1; alu_wb = 1'b1;
            end
            OP_ADC: begin
                wide = {1'b0, rx_val} + {1'b0, ry_val}
                     + {{WORD_SIZE{1'b0}}, c_f};
                flag_we = 1'b1; alu_wb = 1'b1;
            end
            OP_SUB: begin
                wide = {1'b0, rx_val} - {1'b0, ry_val};
                flag_we = 1'b1; alu_wb = 1'b1;
            end
            OP_CMP: begin
                wide = {1'b0, rx_val} - {1'b0, ry_val};
                flag_we = 1'b1;
            end
            OP_AND: begin
                wide = {1'b0, rx_val & ry_val};
                flag_we = 1'b1; alu_wb = 1'b1;
            end
            OP_OR: begin
                wide = {1'b0, rx_val | ry_val};
                flag_we = 1'b1; alu_wb = 1'b1;
            end
            OP_XOR: begin
                wide = {1'b0, rx_val ^ ry_val};
                flag_we = 1'b1; alu_wb = 1'b1;
            end
            OP_MOV: begin
                wide = {1'b0, ry_val};
                alu_wb = 1'b1;
            end
            OP_INC: begin
                wide = {1'b0, rx_val} + (WORD_SIZE+1)'(1);
                flag_we = 1'b1; alu_wb = 1'b1;
            end
            OP_DEC: begin
                wide = {1'b0, rx_val} - (WORD_SIZE+1)'(1);
                flag_we = 1'b1; alu_wb = 1'b1;
            end
            OP_SHR: begin
                wide = {rx_val[0], 1'b0, rx_val[WORD_SIZE-1:1]};
                flag_we = 1'b1; alu_wb = 1'b1;
            end
            OP_SHL: begin
                wide = {rx_val, 1'b0};
                flag_we = 1'b1; alu_wb = 1'b1;
            end
            OP_SET: begin
                reg_we = 1'b1; reg_wdata = m;
            end
            OP_STR: begin
                mem_we = 1'b1; mem_addr = m; mem_wdata = rx_val;
            end
            OP_LOAD: begin
                reg_we = 1'b1; reg_wdata = dmem[m];
            end
            OP_RSTR: begin
                mem_we = 1'b1; mem_addr = rx_val; mem_wdata = ry_val;
            end
            OP_RLOAD: begin
                reg_we = 1'b1; reg_wdata = dmem[ry_val];
            end
            OP_JMP: pc_next = m;
            OP_JC:  if (c_f) pc_next = m;
            OP_JZ:  if (z_f) pc_next = m;
            OP_JN:  if (n_f) pc_next = m;
            default: begin
                valid   = 1'b0;
                pc_next = pc;
            end
        endcase
        if (alu_wb) begin
            reg_we    = 1'b1;
            reg_wdata = wide[WORD_SIZE-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= '0;
            c_f    <= 1'b0;
            z_f    <= 1'b0;
            n_f    <= 1'b0;
            halted <= 1'b0;
            for (int i = 0; i < NUM_REGISTERS; i++)
                regs[i] <= '0;
        end else if (!halted) begin
            if (!valid) begin
                halted <= 1'b1;
            end else begin
                pc <= pc_next;
                if (reg_we)
                    regs[rx] <= reg_wdata;
                if (flag_we) begin
                    c_f <= wide[WORD_SIZE];
                    z_f <= (wide[WORD_SIZE-1:0] == '0);
                    n_f <= wide[WORD_SIZE-1];
                end
            end
        end
    end

    // Program load ignores reset so a program can be written while held.
    always_ff @(posedge clk) begin
        if (imem_we)
            imem[imem_waddr] <= imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst && !halted && valid && mem_we)
            dmem[mem_addr] <= mem_wdata;
    end

    assign dbg_reg_data = regs[dbg_reg_idx];
    assign dbg_mem_data = dmem[dbg_mem_addr];
    assign flags        = {c_f, z_f, n_f};

endmodule

// File: tb/tb_orgasmall_core.sv
// Scoreboard bench for orgasmall_core: programs are loaded under reset,
// expectations queued with the stimulus and drained after each run.
module tb_orgasmall_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic [2:0]  dbg_reg_idx;
    logic [7:0]  dbg_reg_data;
    logic [7:0]  dbg_mem_addr;
    logic [7:0]  dbg_mem_data;
    logic [7:0]  pc;
    logic [2:0]  flags;
    logic        halted;

    orgasmall_core dut (
        .clk(clk), .rst(rst),
        .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .dbg_reg_idx(dbg_reg_idx), .dbg_reg_data(dbg_reg_data),
        .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(dbg_mem_data),
        .pc(pc), .flags(flags), .halted(halted)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] ADD = 5'b00001, ADC = 5'b00010, SUB = 5'b00011;
    localparam logic [4:0] AND = 5'b00100, OR = 5'b00101, XOR = 5'b00110;
    localparam logic [4:0] CMP = 5'b00111, MOV = 5'b01000, STR = 5'b10000;
    localparam logic [4:0] LOAD = 5'b10001, RSTR = 5'b10010;
    localparam logic [4:0] RLOAD = 5'b10011, JC = 5'b10101;
    localparam logic [4:0] JZ = 5'b10110, INC = 5'b11000, DEC = 5'b11001;
    localparam logic [4:0] SHR = 5'b11010, SHL = 5'b11011, SET = 5'b11111;
    localparam logic [15:0] HLT = 16'h0000;

    typedef enum int {K_REG, K_MEM, K_PC, K_FLAGS, K_HALT} kind_t;
    typedef struct {
        string      tag;
        kind_t      kind;
        logic [7:0] sel;
        logic [7:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] pw[$];
    logic [7:0]  pa[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic [15:0] ri(logic [4:0] op, logic [2:0] x,
                                       logic [2:0] y);
        return {op, x, y, 5'b0};
    endfunction

    function automatic logic [15:0] mi(logic [4:0] op, logic [2:0] x,
                                       logic [7:0] mm);
        return {op, x, mm};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] a, input logic [15:0] w);
        pa.push_back(a);
        pw.push_back(w);
    endtask

    // Writes queued words while reset is held, then releases reset.
    task automatic load_and_reset();
        rst = 1'b1;
        while (pw.size() > 0) begin
            imem_we    = 1'b1;
            imem_waddr = pa.pop_front();
            imem_wdata = pw.pop_front();
            tick();
        end
        imem_we = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic exp(input string t, input kind_t k, input logic [7:0] s,
                       input logic [7:0] v);
        exp_t e;
        e.tag = t; e.kind = k; e.sel = s; e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            dbg_reg_idx  = e.sel[2:0];
            dbg_mem_addr = e.sel;
            #1;
            case (e.kind)
                K_REG:   chk(e.tag, dbg_reg_data, e.val);
                K_MEM:   chk(e.tag, dbg_mem_data, e.val);
                K_PC:    chk(e.tag, pc, e.val);
                K_FLAGS: chk(e.tag, {5'b0, flags}, e.val);
                default: chk(e.tag, {7'b0, halted}, e.val);
            endcase
        end
    endtask

    initial begin
        rst = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        dbg_reg_idx = '0; dbg_mem_addr = '0;

        // reset state
        put(8'd0, HLT);
        load_and_reset();
        exp("rst_pc", K_PC, 0, 8'h00);
        exp("rst_flags", K_FLAGS, 0, 8'h00);
        exp("rst_halt", K_HALT, 0, 8'h00);
        exp("rst_r5", K_REG, 5, 8'h00);
        drain();

        // add
        put(0, mi(SET, 1, 8'd5)); put(1, mi(SET, 2, 8'd3));
        put(2, ri(ADD, 1, 2));    put(3, HLT);
        load_and_reset();
        run(3);
        exp("add_r1", K_REG, 1, 8'd8);
        exp("add_flags", K_FLAGS, 0, 8'h00);
        exp("add_pc", K_PC, 0, 8'd3);
        exp("add_run", K_HALT, 0, 8'h00);
        drain();
        run(1);
        exp("end_halt", K_HALT, 0, 8'h01);
        exp("end_pc", K_PC, 0, 8'd3);
        drain();

        // inc wrap and adc with carry-in
        put(0, mi(SET, 1, 8'hFF)); put(1, ri(INC, 1, 0));
        put(2, ri(ADC, 2, 3));     put(3, HLT);
        load_and_reset();
        run(2);
        exp("inc_r1", K_REG, 1, 8'h00);
        exp("inc_flags", K_FLAGS, 0, 8'b110);
        drain();
        run(1);
        exp("adc_r2", K_REG, 2, 8'h01);
        exp("adc_flags", K_FLAGS, 0, 8'b000);
        drain();

        // memory ops
        put(0, mi(SET, 1, 8'h10)); put(1, mi(STR, 1, 8'h40));
        put(2, mi(LOAD, 3, 8'h40)); put(3, mi(SET, 4, 8'h40));
        put(4, ri(RLOAD, 5, 4));   put(5, mi(SET, 6, 8'h55));
        put(6, ri(RSTR, 4, 6));    put(7, ri(RLOAD, 7, 4));
        put(8, HLT);
        load_and_reset();
        run(5);
        exp("str_mem", K_MEM, 8'h40, 8'h10);
        exp("load_r3", K_REG, 3, 8'h10);
        exp("rload_r5", K_REG, 5, 8'h10);
        drain();
        run(3);
        exp("rstr_mem", K_MEM, 8'h40, 8'h55);
        exp("rload_r7", K_REG, 7, 8'h55);
        exp("mem_flags", K_FLAGS, 0, 8'h00);
        exp("mem_pc", K_PC, 0, 8'd8);
        drain();

        // cmp equal, jz taken
        put(0, mi(SET, 1, 8'd2)); put(1, mi(SET, 2, 8'd2));
        put(2, ri(CMP, 1, 2));    put(3, mi(JZ, 0, 8'h20));
        put(4, HLT);              put(8'h20, HLT);
        load_and_reset();
        run(4);
        exp("cmp_r1", K_REG, 1, 8'd2);
        exp("cmpeq_flags", K_FLAGS, 0, 8'b010);
        exp("jz_taken_pc", K_PC, 0, 8'h20);
        drain();

        // cmp less, jz falls through
        put(1, mi(SET, 2, 8'd3));
        load_and_reset();
        run(4);
        exp("cmplt_flags", K_FLAGS, 0, 8'b101);
        exp("jz_fall_pc", K_PC, 0, 8'd4);
        exp("cmplt_r1", K_REG, 1, 8'd2);
        drain();

        // shifts
        put(0, mi(SET, 1, 8'h81)); put(1, ri(SHR, 1, 0));
        put(2, ri(SHL, 1, 0));     put(3, HLT);
        load_and_reset();
        run(2);
        exp("shr_r1", K_REG, 1, 8'h40);
        exp("shr_flags", K_FLAGS, 0, 8'b100);
        drain();
        run(1);
        exp("shl_r1", K_REG, 1, 8'h80);
        exp("shl_flags", K_FLAGS, 0, 8'b001);
        drain();

        // dec borrow from zero, jc taken
        put(0, mi(SET, 1, 8'd0)); put(1, ri(DEC, 1, 0));
        put(2, mi(JC, 0, 8'h30)); put(3, HLT); put(8'h30, HLT);
        load_and_reset();
        run(2);
        exp("dec_r1", K_REG, 1, 8'hFF);
        exp("dec_flags", K_FLAGS, 0, 8'b101);
        drain();
        run(1);
        exp("jc_pc", K_PC, 0, 8'h30);
        drain();

        // logic ops, mov, sub to zero
        put(0, mi(SET, 1, 8'hF0)); put(1, mi(SET, 2, 8'h3C));
        put(2, ri(XOR, 1, 2));     put(3, ri(MOV, 3, 1));
        put(4, mi(SET, 4, 8'h0F)); put(5, ri(AND, 4, 1));
        put(6, ri(OR, 4, 2));      put(7, ri(SUB, 4, 2));
        put(8, HLT);
        load_and_reset();
        run(4);
        exp("xor_r1", K_REG, 1, 8'hCC);
        exp("mov_r3", K_REG, 3, 8'hCC);
        exp("mov_flags", K_FLAGS, 0, 8'b001);
        drain();
        run(2);
        exp("and_r4", K_REG, 4, 8'h0C);
        exp("and_flags", K_FLAGS, 0, 8'b000);
        drain();
        run(2);
        exp("sub_r4", K_REG, 4, 8'h00);
        exp("sub_flags", K_FLAGS, 0, 8'b010);
        drain();

        // invalid opcode halts, reset recovers
        put(0, mi(SET, 1, 8'd7)); put(1, mi(SET, 2, 8'd9));
        put(2, HLT);
        load_and_reset();
        run(5);
        exp("inv_pc", K_PC, 0, 8'd2);
        exp("inv_halt", K_HALT, 0, 8'h01);
        exp("inv_r1", K_REG, 1, 8'd7);
        exp("inv_r2", K_REG, 2, 8'd9);
        drain();
        rst = 1'b1;
        tick();
        exp("rrst_pc", K_PC, 0, 8'd0);
        exp("rrst_halt", K_HALT, 0, 8'h00);
        exp("rrst_r1", K_REG, 1, 8'd0);
        drain();
        rst = 1'b0;
        run(1);
        exp("rerun_r1", K_REG, 1, 8'd7);
        exp("rerun_pc", K_PC, 0, 8'd1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
